// File: rtl/wb_arbiter_2.sv
// ---------------------------------------------------------------------------
// wb_arbiter_2
//
// Shares one downstream Wishbone slave port between two upstream masters.
// A master requests the bus by raising its cyc_i. The grant is registered and
// is held for as long as the owning master keeps cyc_i high, so any number of
// strobed transfers inside one cycle stay with the same owner. Arbitration is
// either fixed priority (selectable winner on ties) or round robin.
//
// Parameters:
//   DATA_WIDTH            data bus width in bits
//   ADDR_WIDTH            address bus width in bits
//   SELECT_WIDTH          byte select width
//   ARB_TYPE_ROUND_ROBIN  0 = fixed priority, 1 = round robin
//   ARB_LSB_HIGH_PRIORITY fixed priority tie winner: 1 = master 0, 0 = master 1
//
// Ports:
//   clk, rst                      clock and synchronous active-high reset
//   wbm0_*, wbm1_*                master-side ports (adr/dat/we/sel/stb/cyc in,
//                                 dat/ack/err/rty out)
//   wbs_*                         slave-side port (adr/dat/we/sel/stb/cyc out,
//                                 dat/ack/err/rty in)
// ---------------------------------------------------------------------------
module wb_arbiter_2 #(
    parameter int DATA_WIDTH            = 32,
    parameter int ADDR_WIDTH            = 32,
    parameter int SELECT_WIDTH          = DATA_WIDTH / 8,
    parameter int ARB_TYPE_ROUND_ROBIN  = 0,
    parameter int ARB_LSB_HIGH_PRIORITY = 1
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic [ADDR_WIDTH-1:0]   wbm0_adr_i,
    input  logic [DATA_WIDTH-1:0]   wbm0_dat_i,
    output logic [DATA_WIDTH-1:0]   wbm0_dat_o,
    input  logic                    wbm0_we_i,
    input  logic [SELECT_WIDTH-1:0] wbm0_sel_i,
    input  logic                    wbm0_stb_i,
    output logic                    wbm0_ack_o,
    output logic                    wbm0_err_o,
    output logic                    wbm0_rty_o,
    input  logic                    wbm0_cyc_i,

    input  logic [ADDR_WIDTH-1:0]   wbm1_adr_i,
    input  logic [DATA_WIDTH-1:0]   wbm1_dat_i,
    output logic [DATA_WIDTH-1:0]   wbm1_dat_o,
    input  logic                    wbm1_we_i,
    input  logic [SELECT_WIDTH-1:0] wbm1_sel_i,
    input  logic                    wbm1_stb_i,
    output logic                    wbm1_ack_o,
    output logic                    wbm1_err_o,
    output logic                    wbm1_rty_o,
    input  logic                    wbm1_cyc_i,

    output logic [ADDR_WIDTH-1:0]   wbs_adr_o,
    input  logic [DATA_WIDTH-1:0]   wbs_dat_i,
    output logic [DATA_WIDTH-1:0]   wbs_dat_o,
    output logic                    wbs_we_o,
    output logic [SELECT_WIDTH-1:0] wbs_sel_o,
    output logic                    wbs_stb_o,
    input  logic                    wbs_ack_i,
    input  logic                    wbs_err_i,
    input  logic                    wbs_rty_i,
    output logic                    wbs_cyc_o
);

    logic grant_valid_reg, grant_valid_next;
    logic grant_reg, grant_next;
    logic last_grant_reg, last_grant_next;
    logic owner_cyc;
    logic tie_winner;

    // cyc_i of whichever master currently holds (or last held) the grant
    assign owner_cyc = grant_reg ? wbm1_cyc_i : wbm0_cyc_i;

    // On a tie, round robin favours the master that did not win last time
    assign tie_winner = (ARB_TYPE_ROUND_ROBIN != 0) ? ~last_grant_reg
                                                    : (ARB_LSB_HIGH_PRIORITY == 0);

    // Grant decision: keep the current owner while its cycle is open,
    // otherwise re-arbitrate among the masters requesting right now
    always_comb begin
        grant_valid_next = grant_valid_reg;
        grant_next       = grant_reg;
        last_grant_next  = last_grant_reg;
        if (!(grant_valid_reg && owner_cyc)) begin
            if (!wbm0_cyc_i && !wbm1_cyc_i) begin
                grant_valid_next = 1'b0;
            end else begin
                grant_valid_next = 1'b1;
                if (wbm0_cyc_i && wbm1_cyc_i) begin
                    grant_next = tie_winner;
                end else begin
                    grant_next = wbm1_cyc_i;
                end
                last_grant_next = grant_next;
            end
        end
    end

    // Grant state; reset leaves master 1 as "last winner" so master 0 takes
    // the first round-robin tie
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_valid_reg <= 1'b0;
            grant_reg       <= 1'b0;
            last_grant_reg  <= 1'b1;
        end else begin
            grant_valid_reg <= grant_valid_next;
            grant_reg       <= grant_next;
            last_grant_reg  <= last_grant_next;
        end
    end

    // Combinational routing from the registered grant; with no valid grant
    // the slave side is fully quiet and no termination reaches either master
    always_comb begin
        wbs_adr_o  = '0;
        wbs_dat_o  = '0;
        wbs_we_o   = 1'b0;
        wbs_sel_o  = '0;
        wbs_stb_o  = 1'b0;
        wbs_cyc_o  = 1'b0;
        wbm0_ack_o = 1'b0;
        wbm0_err_o = 1'b0;
        wbm0_rty_o = 1'b0;
        wbm1_ack_o = 1'b0;
        wbm1_err_o = 1'b0;
        wbm1_rty_o = 1'b0;
        if (grant_valid_reg) begin
            if (grant_reg) begin
                wbs_adr_o  = wbm1_adr_i;
                wbs_dat_o  = wbm1_dat_i;
                wbs_we_o   = wbm1_we_i;
                wbs_sel_o  = wbm1_sel_i;
                wbs_stb_o  = wbm1_stb_i;
                wbs_cyc_o  = wbm1_cyc_i;
                wbm1_ack_o = wbs_ack_i;
                wbm1_err_o = wbs_err_i;
                wbm1_rty_o = wbs_rty_i;
            end else begin
                wbs_adr_o  = wbm0_adr_i;
                wbs_dat_o  = wbm0_dat_i;
                wbs_we_o   = wbm0_we_i;
                wbs_sel_o  = wbm0_sel_i;
                wbs_stb_o  = wbm0_stb_i;
                wbs_cyc_o  = wbm0_cyc_i;
                wbm0_ack_o = wbs_ack_i;
                wbm0_err_o = wbs_err_i;
                wbm0_rty_o = wbs_rty_i;
            end
        end
    end

    // Read data is broadcast; only the acknowledged master will sample it
    assign wbm0_dat_o = wbs_dat_i;
    assign wbm1_dat_o = wbs_dat_i;

endmodule
